// File: rtl/bpu_update_ctrl_pkg.sv
// rtl/bpu_update_ctrl_pkg.sv - shared types for the branch predictor update controller
package bpu_update_ctrl_pkg;

  localparam int XLEN = 32;

  // One resolved-branch update as captured from EX
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            is_branch;
    logic            is_jump;
  } bpu_update_t;

  typedef enum logic {
    BPU_INIT = 1'b0,
    BPU_RUN  = 1'b1
  } bpu_ctrl_state_e;

endpackage

// File: rtl/bpu_update_ctrl_fifo.sv
// rtl/bpu_update_ctrl_fifo.sv - update FIFO with flush and explicit occupancy counter
module bpu_update_fifo
  import bpu_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  bpu_update_t                push_data,
  input  logic                       pop,
  output bpu_update_t                head,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] occ_q;
  bpu_update_t   mem_q [DEPTH];

  // Pointers wrap naturally (DEPTH is a power of two); flush empties the queue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head      = mem_q[rd_ptr_q];
  assign full      = (occ_q == OW'(DEPTH));
  assign occupancy = occ_q;

endmodule

// File: rtl/bpu_update_ctrl.sv
// rtl/bpu_update_ctrl.sv - predictor table write sequencer (clear sweep, update FIFO, optional BPU_UPDATE_BYPASS_EN)
module bpu_update_ctrl
  import bpu_update_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int INIT_ENTRIES = 256
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              ex_valid,
  output logic                              ex_ready,
  input  logic [XLEN-1:0]                   ex_pc,
  input  logic [XLEN-1:0]                   ex_target,
  input  logic                              ex_taken,
  input  logic                              ex_is_branch,
  input  logic                              ex_is_jump,
  input  logic                              bp_ready,
  output logic                              upd_en,
  output logic [XLEN-1:0]                   upd_pc,
  output logic                              upd_taken,
  output logic                              btb_we,
  output logic [XLEN-1:0]                   btb_pc,
  output logic [XLEN-1:0]                   btb_target,
  output logic                              init_we,
  output logic [$clog2(INIT_ENTRIES)-1:0]   init_index,
  output logic                              init_done,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int IW = $clog2(INIT_ENTRIES);
  localparam int OW = $clog2(DEPTH + 1);

  bpu_ctrl_state_e state_q, state_d;
  logic [IW-1:0]   index_q, index_d;

  bpu_update_t     ex_entry, head, sel;
  logic            fifo_full, running, fifo_issue, bypass, issue, push;
  logic [OW-1:0]   occ;

  // Controller state and sweep index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BPU_INIT;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Sweep advances every cycle independent of bp_ready; RUN is terminal
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      BPU_INIT: begin
        index_d = index_q + 1'b1;
        if (index_q == IW'(INIT_ENTRIES - 1)) begin
          state_d = BPU_RUN;
          index_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign running    = (state_q == BPU_RUN);
  assign ex_ready   = running && !fifo_full;
  assign fifo_issue = running && (occ != '0) && bp_ready && !flush;

`ifdef BPU_UPDATE_BYPASS_EN
  assign bypass = running && (occ == '0) && ex_valid && ex_ready && bp_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign issue    = fifo_issue || bypass;
  assign push     = ex_valid && ex_ready && !flush && !bypass;
  assign ex_entry = '{pc: ex_pc, target: ex_target, taken: ex_taken,
                      is_branch: ex_is_branch, is_jump: ex_is_jump};
  assign sel      = fifo_issue ? head : ex_entry;

  bpu_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (ex_entry),
    .pop       (fifo_issue),
    .head      (head),
    .full      (fifo_full),
    .occupancy (occ)
  );

  // Table write strobes; payload buses are held at zero when nothing issues
  always_comb begin
    upd_en     = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    btb_we     = 1'b0;
    btb_pc     = '0;
    btb_target = '0;
    if (issue) begin
      upd_en     = sel.is_branch;
      upd_pc     = sel.pc;
      upd_taken  = sel.taken;
      btb_we     = sel.taken && (sel.is_branch || sel.is_jump);
      btb_pc     = sel.pc;
      btb_target = sel.target;
    end
  end

  // Clear strobe must read 0 while reset is held, so it is qualified by reset_n
  assign init_we    = (state_q == BPU_INIT) && reset_n;
  assign init_index = init_we ? index_q : '0;
  assign init_done  = running;
  assign occupancy  = occ;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb/tb_bpu_update_ctrl.sv - self-checking bench for bpu_update_ctrl
module tb_bpu_update_ctrl;
  import bpu_update_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int INIT_ENTRIES = 256;

  logic            clk, reset_n, flush, ex_valid, ex_ready;
  logic [XLEN-1:0] ex_pc, ex_target, upd_pc, btb_pc, btb_target;
  logic            ex_taken, ex_is_branch, ex_is_jump, bp_ready;
  logic            upd_en, upd_taken, btb_we, init_we, init_done;
  logic [7:0]      init_index;
  logic [2:0]      occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  bpu_update_ctrl #(.DEPTH(DEPTH), .INIT_ENTRIES(INIT_ENTRIES)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .bp_ready(bp_ready), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .btb_we(btb_we), .btb_pc(btb_pc), .btb_target(btb_target),
    .init_we(init_we), .init_index(init_index), .init_done(init_done), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                        input logic tk, input logic br, input logic jp);
    ex_valid = v; ex_pc = pc; ex_target = tgt; ex_taken = tk; ex_is_branch = br; ex_is_jump = jp;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; bp_ready = 1'b0;
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++;
    if ({init_we, ex_ready, init_done, upd_en, btb_we, occupancy} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b exp %b", {init_we, ex_ready, init_done, upd_en, btb_we, occupancy}, 8'b0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < INIT_ENTRIES; i++) begin
      n_checks++;
      if ({init_we, ex_ready, init_done, init_index} !== {1'b1, 1'b0, 1'b0, 8'(i)}) begin
        n_fail++;
        $display("FAIL sweep_cycle_%0d: got we/rdy/done/idx %b/%b/%b/%0d exp 1/0/0/%0d",
                 i, init_we, ex_ready, init_done, init_index, i);
      end
      next_cycle();
    end
    n_checks++;
    if ({init_done, ex_ready, init_we} !== 3'b110) begin
      n_fail++;
      $display("FAIL sweep_done: got done/rdy/we %b exp 110", {init_done, ex_ready, init_we});
    end
  endtask

  task automatic test_basic();
    set_ex(1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 1'b0);
    bp_ready = 1'b1;
    #1;
`ifdef BPU_UPDATE_BYPASS_EN
    n_checks++;
    if ({upd_en, upd_taken, btb_we, upd_pc, btb_target} !== {3'b111, 32'h100, 32'h80}) begin
      n_fail++;
      $display("FAIL basic_bypass_issue: got %b pc %h tgt %h exp 111 pc 100 tgt 80", {upd_en, upd_taken, btb_we}, upd_pc, btb_target);
    end
    next_cycle();
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({upd_en, btb_we, occupancy} !== 5'b0) begin
      n_fail++;
      $display("FAIL basic_after: got %b exp 00000", {upd_en, btb_we, occupancy});
    end
`else
    n_checks++;
    if ({upd_en, btb_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_no_same_cycle: got %b exp 00", {upd_en, btb_we});
    end
    next_cycle();
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({upd_en, upd_taken, btb_we, upd_pc, btb_pc, btb_target} !== {3'b111, 32'h100, 32'h100, 32'h80}) begin
      n_fail++;
      $display("FAIL basic_issue: got %b pc %h bpc %h tgt %h exp 111 100 100 80", {upd_en, upd_taken, btb_we}, upd_pc, btb_pc, btb_target);
    end
`endif
    next_cycle();
  endtask

  task automatic test_branch_kinds();
    bp_ready = 1'b0;
    set_ex(1'b1, 32'h200, 32'h999, 1'b0, 1'b1, 1'b0); next_cycle();
    set_ex(1'b1, 32'h300, 32'h400, 1'b1, 1'b0, 1'b1); next_cycle();
    set_ex(1'b1, 32'h600, 32'h700, 1'b1, 1'b0, 1'b0); next_cycle();
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (occupancy !== 3'd3) begin
      n_fail++;
      $display("FAIL kinds_queued: occupancy got %0d exp 3", occupancy);
    end
    bp_ready = 1'b1;
    #1;
    n_checks++;
    if ({upd_en, upd_taken, btb_we, upd_pc} !== {3'b100, 32'h200}) begin
      n_fail++;
      $display("FAIL kinds_not_taken: got %b pc %h exp 100 pc 200", {upd_en, upd_taken, btb_we}, upd_pc);
    end
    next_cycle();
    n_checks++;
    if ({upd_en, btb_we, btb_pc, btb_target} !== {2'b01, 32'h300, 32'h400}) begin
      n_fail++;
      $display("FAIL kinds_jal: got %b pc %h tgt %h exp 01 300 400", {upd_en, btb_we}, btb_pc, btb_target);
    end
    next_cycle();
    n_checks++;
    if ({upd_en, btb_we, occupancy} !== {2'b00, 3'd1}) begin
      n_fail++;
      $display("FAIL kinds_plain: got %b occ %0d exp 00 occ 1", {upd_en, btb_we}, occupancy);
    end
    next_cycle();
    n_checks++;
    if (occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL kinds_drained: occupancy got %0d exp 0", occupancy);
    end
  endtask

  task automatic test_backpressure();
    bp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_ex(1'b1, 32'(i * 16), 32'(i * 16 + 32'h1000), 1'b1, 1'b1, 1'b0);
      next_cycle();
    end
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({occupancy, ex_ready} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_full: occ %0d rdy %b exp occ 4 rdy 0", occupancy, ex_ready);
    end
    bp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if ({upd_en, btb_we, upd_pc, btb_target} !== {2'b11, 32'(i * 16), 32'(i * 16 + 32'h1000)}) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got %b pc %h tgt %h exp 11 pc %h", i, {upd_en, btb_we}, upd_pc, btb_target, i * 16);
      end
      next_cycle();
    end
    n_checks++;
    if ({occupancy, upd_en, btb_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got occ %0d strobes %b exp 0", occupancy, {upd_en, btb_we});
    end
  endtask

  task automatic test_flush();
    bp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 32'h800 + 32'(i), 32'h900, 1'b1, 1'b1, 1'b0);
      next_cycle();
    end
    set_ex(1'b1, 32'hA00, 32'hB00, 1'b1, 1'b1, 1'b1);
    flush = 1'b1; bp_ready = 1'b1;
    #1;
    n_checks++;
    if ({upd_en, btb_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_cycle: strobes got %b exp 00", {upd_en, btb_we});
    end
    next_cycle();
    flush = 1'b0;
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({occupancy, upd_en, btb_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL flush_after: occ %0d strobes %b exp 0", occupancy, {upd_en, btb_we});
    end
    next_cycle();
    n_checks++;
    if ({upd_en, btb_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_later: strobes got %b exp 00", {upd_en, btb_we});
    end
  endtask

  task automatic test_bypass();
    bp_ready = 1'b1;
    set_ex(1'b1, 32'h500, 32'h5A0, 1'b1, 1'b1, 1'b0);
    #1;
`ifdef BPU_UPDATE_BYPASS_EN
    n_checks++;
    if ({btb_we, btb_pc, occupancy} !== {1'b1, 32'h500, 3'd0}) begin
      n_fail++;
      $display("FAIL bypass_same: we %b pc %h occ %0d exp 1 500 0", btb_we, btb_pc, occupancy);
    end
    next_cycle();
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({btb_we, occupancy} !== 4'b0) begin
      n_fail++;
      $display("FAIL bypass_next: we %b occ %0d exp 0 0", btb_we, occupancy);
    end
`else
    n_checks++;
    if (btb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL nobypass_same: we got %b exp 0", btb_we);
    end
    next_cycle();
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({btb_we, btb_pc, btb_target, occupancy} !== {1'b1, 32'h500, 32'h5A0, 3'd1}) begin
      n_fail++;
      $display("FAIL nobypass_next: we %b pc %h tgt %h occ %0d exp 1 500 5a0 1", btb_we, btb_pc, btb_target, occupancy);
    end
`endif
    next_cycle();
  endtask

  task automatic test_random();
    bpu_update_t mq[$];
    bpu_update_t ex, h;
    logic v, bpr, fl, fifo_iss, byp, e_ready, e_upd, e_btb;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 99) < 60);
      bpr = ($urandom_range(0, 99) < 65);
      fl  = ($urandom_range(0, 99) < 4);
      ex  = '{pc: $urandom, target: $urandom, taken: 1'($urandom),
              is_branch: 1'($urandom), is_jump: 1'($urandom)};
      set_ex(v, ex.pc, ex.target, ex.taken, ex.is_branch, ex.is_jump);
      bp_ready = bpr; flush = fl;
      #1;
      e_ready  = (mq.size() < DEPTH);
      fifo_iss = (mq.size() > 0) && bpr && !fl;
      byp      = 1'b0;
`ifdef BPU_UPDATE_BYPASS_EN
      byp      = (mq.size() == 0) && v && bpr && !fl;
`endif
      h     = fifo_iss ? mq[0] : ex;
      e_upd = (fifo_iss || byp) && h.is_branch;
      e_btb = (fifo_iss || byp) && h.taken && (h.is_branch || h.is_jump);
      n_checks++;
      if ({upd_en, btb_we, ex_ready, occupancy} !== {e_upd, e_btb, e_ready, 3'(mq.size())}) begin
        n_fail++;
        $display("FAIL rand_ctrl_%0d: got upd/btb/rdy/occ %b/%b/%b/%0d exp %b/%b/%b/%0d",
                 c, upd_en, btb_we, ex_ready, occupancy, e_upd, e_btb, e_ready, mq.size());
      end
      if (e_upd || e_btb) begin
        n_checks++;
        if ({upd_pc, btb_pc, btb_target, upd_taken} !== {h.pc, h.pc, h.target, h.taken}) begin
          n_fail++;
          $display("FAIL rand_data_%0d: got pc %h/%h tgt %h tk %b exp pc %h tgt %h tk %b",
                   c, upd_pc, btb_pc, btb_target, upd_taken, h.pc, h.target, h.taken);
        end
      end
      if (fl) mq.delete();
      else begin
        if (fifo_iss) void'(mq.pop_front());
        if (v && e_ready && !byp) mq.push_back(ex);
      end
      next_cycle();
    end
    flush = 1'b1; set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    logic leaked;
    bp_ready = 1'b0;
    set_ex(1'b1, 32'hC00, 32'hC80, 1'b1, 1'b1, 1'b0); next_cycle();
    set_ex(1'b1, 32'hD00, 32'hD80, 1'b1, 1'b1, 1'b0); next_cycle();
    set_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    bp_ready = 1'b1;
    #1;
    n_checks++;
    if ({upd_en, upd_pc, occupancy} !== {1'b1, 32'hC00, 3'd2}) begin
      n_fail++;
      $display("FAIL mid_drain_pre: en %b pc %h occ %0d exp 1 c00 2", upd_en, upd_pc, occupancy);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({upd_en, btb_we, ex_ready, init_we, init_done, occupancy, upd_pc} !== '0) begin
      n_fail++;
      $display("FAIL mid_drain_reset: got %b pc %h exp all 0", {upd_en, btb_we, ex_ready, init_we, init_done, occupancy}, upd_pc);
    end
    next_cycle();
    reset_n = 1'b1;
    #1;
    leaked = 1'b0;
    for (int i = 0; i < INIT_ENTRIES; i++) begin
      n_checks++;
      if ({init_we, init_index} !== {1'b1, 8'(i)}) begin
        n_fail++;
        $display("FAIL resweep_%0d: we %b idx %0d exp 1 %0d", i, init_we, init_index, i);
      end
      if (upd_en || btb_we) leaked = 1'b1;
      next_cycle();
    end
    #1;
    if (upd_en || btb_we) leaked = 1'b1;
    n_checks++;
    if ({leaked, init_done, occupancy} !== {1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL resweep_end: leaked %b done %b occ %0d exp 0 1 0", leaked, init_done, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch_kinds();
    test_backpressure();
    test_flush();
    test_bypass();
    test_random();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
